// File: rtl/rv32_pkg.sv
// rv32_pkg: shared opcodes, ALU encodings, exception codes and SYSTEM words for the RV32IM execute stage
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // M-extension codes sit at 16..23 in funct3 order so R-type decode can form them directly
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        AOP_ADD = 2'b00,
        AOP_BR  = 2'b01,
        AOP_R   = 2'b10,
        AOP_I   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_t;

    localparam logic [31:0] EXC_ILLEGAL = 32'd2;
    localparam logic [31:0] EXC_BREAK   = 32'd3;
    localparam logic [31:0] EXC_ECALL   = 32'd11;

    localparam logic [31:0] WORD_ECALL  = 32'h00000073;
    localparam logic [31:0] WORD_EBREAK = 32'h00100073;
    localparam logic [31:0] WORD_MRET   = 32'h30200073;

endpackage

// File: rtl/rv32im_alu.sv
// rv32im_alu: combinational RV32IM arithmetic unit
module rv32im_alu
    import rv32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_ctrl_t   ctrl,
    output logic [31:0] result,
    output logic        zero
);

    logic        a_sx;
    logic        b_sx;
    logic [63:0] prod;
    logic        div_zero;
    logic        div_ovf;
    logic signed [31:0] sdiv;
    logic signed [31:0] srem;
    logic signed [31:0] sra_r;

    // one 64-bit multiplier; operand extension picks signed/unsigned high half
    assign a_sx     = (ctrl == ALU_MULH || ctrl == ALU_MULHSU) & a[31];
    assign b_sx     = (ctrl == ALU_MULH) & b[31];
    assign prod     = {{32{a_sx}}, a} * {{32{b_sx}}, b};
    assign div_zero = b == 32'd0;
    assign div_ovf  = a == 32'h80000000 && b == 32'hFFFFFFFF;
    assign sdiv     = (div_zero || div_ovf) ? 32'sd0 : $signed(a) / $signed(b);
    assign srem     = (div_zero || div_ovf) ? 32'sd0 : $signed(a) % $signed(b);
    assign sra_r    = $signed(a) >>> b[4:0];

    // operation select, with divide-by-zero and overflow results fixed explicitly
    always_comb begin
        case (ctrl)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {31'd0, a < b};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = sra_r;
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_MUL:    result = prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  result = prod[63:32];
            ALU_DIV:    result = div_zero ? 32'hFFFFFFFF : div_ovf ? 32'h80000000 : sdiv;
            ALU_DIVU:   result = div_zero ? 32'hFFFFFFFF : a / b;
            ALU_REM:    result = div_zero ? a : srem;
            ALU_REMU:   result = div_zero ? a : a % b;
            default:    result = 32'd0;
        endcase
    end

    assign zero = result == 32'd0;

endmodule

// File: rtl/rv32im_exec_ctrl.sv
// rv32im_exec_ctrl: decode control, ALU control, RV32IM ALU, branch compare, traps and retire counter
module rv32im_exec_ctrl
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic            reg_write,
    output logic            alu_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            branch,
    output logic            jump,
    output logic            jump_r,
    output logic [2:0]      branch_type,
    output logic            branch_taken,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            is_csr,
    output logic            csr_read_en,
    output logic            csr_write_en,
    output logic            trap_enter,
    output logic            trap_exit,
    output logic [31:0]     exception_code,
    output logic [31:0]     instret
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    alu_op_t    alu_op;
    alu_ctrl_t  alu_ctrl;
    a_sel_t     a_sel;
    b_sel_t     b_sel;
    logic [XLEN-1:0] a_op;
    logic [XLEN-1:0] b_op;
    logic       cond;

    assign opc         = instr[6:0];
    assign f3          = instr[14:12];
    assign f7          = instr[31:25];
    assign rd          = instr[11:7];
    assign rs1         = instr[19:15];
    assign branch_type = f3;

    // main decode, trap detection, then trap squashing of side-effecting controls
    always_comb begin
        reg_write      = 1'b0;
        alu_src        = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_to_reg     = 1'b0;
        branch         = 1'b0;
        jump           = 1'b0;
        jump_r         = 1'b0;
        is_csr         = 1'b0;
        csr_read_en    = 1'b0;
        csr_write_en   = 1'b0;
        trap_enter     = 1'b0;
        trap_exit      = 1'b0;
        exception_code = 32'd0;
        alu_op         = AOP_ADD;
        a_sel          = A_RS1;
        b_sel          = B_RS2;
        case (opc)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = AOP_R;
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = AOP_I;
                b_sel     = B_IMM;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                b_sel      = B_IMM;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                b_sel     = B_IMM;
            end
            OP_BRANCH: begin
                branch = 1'b1;
                alu_op = AOP_BR;
            end
            OP_JAL: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                a_sel     = A_PC;
                b_sel     = B_FOUR;
            end
            OP_JALR: begin
                reg_write = 1'b1;
                jump_r    = 1'b1;
                a_sel     = A_PC;
                b_sel     = B_FOUR;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                a_sel     = A_ZERO;
                b_sel     = B_IMM;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                a_sel     = A_PC;
                b_sel     = B_IMM;
            end
            OP_SYSTEM: begin
                if (f3 != 3'b000) begin
                    is_csr       = 1'b1;
                    csr_read_en  = 1'b1;
                    reg_write    = rd != 5'd0;
                    csr_write_en = f3[1:0] == 2'b01 || rs1 != 5'd0;
                end else if (instr == WORD_ECALL) begin
                    trap_enter     = 1'b1;
                    exception_code = EXC_ECALL;
                end else if (instr == WORD_EBREAK) begin
                    trap_enter     = 1'b1;
                    exception_code = EXC_BREAK;
                end else if (instr == WORD_MRET) begin
                    trap_exit = 1'b1;
                end else begin
                    trap_enter     = 1'b1;
                    exception_code = EXC_ILLEGAL;
                end
            end
            default: begin
                trap_enter     = 1'b1;
                exception_code = EXC_ILLEGAL;
            end
        endcase
        if (trap_enter || trap_exit) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
            mem_read  = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
            jump_r    = 1'b0;
        end
    end

    // ALU control: op class plus funct3/funct7 to the internal ALU code
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            AOP_BR: alu_ctrl = ALU_SUB;
            AOP_R, AOP_I: begin
                if (alu_op == AOP_R && f7 == F7_MULDIV) alu_ctrl = alu_ctrl_t'({2'b10, f3});
                else case (f3)
                    3'b000:  alu_ctrl = (alu_op == AOP_R && f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    assign a_op = a_sel == A_PC ? pc : a_sel == A_ZERO ? '0 : rs1_val;
    assign b_op = b_sel == B_IMM ? imm : b_sel == B_FOUR ? XLEN'(4) : rs2_val;

    rv32im_alu u_alu (
        .a      (a_op),
        .b      (b_op),
        .ctrl   (alu_ctrl),
        .result (alu_result),
        .zero   (zero)
    );

    // branch condition on the raw register operands
    always_comb begin
        case (f3)
            3'b000:  cond = rs1_val == rs2_val;
            3'b001:  cond = rs1_val != rs2_val;
            3'b100:  cond = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  cond = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  cond = rs1_val < rs2_val;
            3'b111:  cond = rs1_val >= rs2_val;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = branch & cond;

    // retired-cycle counter, free-running and wrapping
    always_ff @(posedge clk) begin
        if (rst) instret <= 32'd0;
        else instret <= instret + 32'd1;
    end

endmodule

// File: tb/tb_rv32im_exec_ctrl.sv
// tb_rv32im_exec_ctrl: directed self-checking bench for rv32im_exec_ctrl
module tb_rv32im_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic [31:0] imm = 32'd0;
    logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic        branch, jump, jump_r, branch_taken, zero;
    logic [2:0]  branch_type;
    logic [31:0] alu_result;
    logic        is_csr, csr_read_en, csr_write_en, trap_enter, trap_exit;
    logic [31:0] exception_code, instret;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32im_exec_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jump_r(jump_r),
        .branch_type(branch_type), .branch_taken(branch_taken), .alu_result(alu_result), .zero(zero),
        .is_csr(is_csr), .csr_read_en(csr_read_en), .csr_write_en(csr_write_en),
        .trap_enter(trap_enter), .trap_exit(trap_exit), .exception_code(exception_code), .instret(instret)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd0, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p);
        @(negedge clk);
        instr = i; rs1_val = a; rs2_val = b; imm = im; pc = p;
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %h exp 0", instret); end
        drive(enc_r(7'd0, 3'b000), 32'hB0, 32'h0A, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hBA) begin errors++; $display("FAIL reset_comb_add: got %h exp 000000ba", alu_result); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (instret !== 32'd10) begin errors++; $display("FAIL instret_count: got %0d exp 10", instret); end
    endtask

    task automatic test_rtype;
        drive(enc_r(7'd0, 3'b000), 32'hB0, 32'h0A, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hBA) begin errors++; $display("FAIL add: got %h exp 000000ba", alu_result); end
        checks++; if (reg_write !== 1'b1 || alu_src !== 1'b0) begin errors++; $display("FAIL r_ctrl: got rw=%b src=%b exp rw=1 src=0", reg_write, alu_src); end
        drive(enc_r(7'b0100000, 3'b000), 32'hB0, 32'h0A, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hA6) begin errors++; $display("FAIL sub: got %h exp 000000a6", alu_result); end
        drive(enc_r(7'd0, 3'b001), 32'hB0, 32'h0A, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'h2C000) begin errors++; $display("FAIL sll: got %h exp 0002c000", alu_result); end
        drive(enc_r(7'b0100000, 3'b101), 32'hB0, 32'h0A, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL sra_small: got %h z=%b exp 0 z=1", alu_result, zero); end
        drive(enc_r(7'b0100000, 3'b101), 32'h80000000, 32'd4, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hF8000000) begin errors++; $display("FAIL sra_neg: got %h exp f8000000", alu_result); end
        drive(enc_r(7'd0, 3'b101), 32'h80000000, 32'd4, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'h08000000) begin errors++; $display("FAIL srl: got %h exp 08000000", alu_result); end
        drive(enc_r(7'd0, 3'b010), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'd1) begin errors++; $display("FAIL slt: got %h exp 1", alu_result); end
        drive(enc_r(7'd0, 3'b011), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL sltu: got %h exp 0", alu_result); end
    endtask

    task automatic test_itype;
        drive(enc_i(7'b0100000, 3'b000), 32'd10, 32'd99, 32'd5, 32'd0);
        checks++; if (alu_result !== 32'd15) begin errors++; $display("FAIL addi_f7: got %h exp 0000000f", alu_result); end
        checks++; if (alu_src !== 1'b1 || reg_write !== 1'b1) begin errors++; $display("FAIL i_ctrl: got src=%b rw=%b exp 1 1", alu_src, reg_write); end
        drive(enc_i(7'b0100000, 3'b101), 32'h80000000, 32'd0, 32'h404, 32'd0);
        checks++; if (alu_result !== 32'hF8000000) begin errors++; $display("FAIL srai: got %h exp f8000000", alu_result); end
    endtask

    task automatic test_mdiv;
        drive(enc_r(7'd1, 3'b000), 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul: got %h exp ffffffeb", alu_result); end
        drive(enc_r(7'd1, 3'b011), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu: got %h exp fffffffe", alu_result); end
        drive(enc_r(7'd1, 3'b001), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL mulh: got %h exp 0", alu_result); end
        drive(enc_r(7'd1, 3'b010), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu: got %h exp ffffffff", alu_result); end
        drive(enc_r(7'd1, 3'b100), 32'd17, 32'd3, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'd5) begin errors++; $display("FAIL div: got %h exp 5", alu_result); end
        drive(enc_r(7'd1, 3'b110), 32'd17, 32'd3, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'd2) begin errors++; $display("FAIL rem: got %h exp 2", alu_result); end
        drive(enc_r(7'd1, 3'b100), 32'd1234, 32'd0, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero: got %h exp ffffffff", alu_result); end
        drive(enc_r(7'd1, 3'b101), 32'd1234, 32'd0, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero: got %h exp ffffffff", alu_result); end
        drive(enc_r(7'd1, 3'b110), 32'd9, 32'd0, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'd9) begin errors++; $display("FAIL rem_zero: got %h exp 9", alu_result); end
        drive(enc_r(7'd1, 3'b111), 32'd9, 32'd0, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'd9) begin errors++; $display("FAIL remu_zero: got %h exp 9", alu_result); end
        drive(enc_r(7'd1, 3'b100), 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'h80000000) begin errors++; $display("FAIL div_ovf: got %h exp 80000000", alu_result); end
        drive(enc_r(7'd1, 3'b110), 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL rem_ovf: got %h exp 0", alu_result); end
        drive(enc_r(7'd1, 3'b100), 32'hFFFFFFEF, 32'd3, 32'd0, 32'd0);
        checks++; if (alu_result !== 32'hFFFFFFFB) begin errors++; $display("FAIL div_neg: got %h exp fffffffb", alu_result); end
    endtask

    task automatic test_branch;
        drive(enc_b(3'b100), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        checks++; if (branch_taken !== 1'b1 || branch !== 1'b1) begin errors++; $display("FAIL blt: got t=%b b=%b exp 1 1", branch_taken, branch); end
        drive(enc_b(3'b110), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bltu: got %b exp 0", branch_taken); end
        drive(enc_b(3'b101), 32'd5, 32'd5, 32'd0, 32'd0);
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bge: got %b exp 1", branch_taken); end
        drive(enc_b(3'b000), 32'd5, 32'd5, 32'd0, 32'd0);
        checks++; if (branch_taken !== 1'b1 || zero !== 1'b1 || branch_type !== 3'b000) begin errors++; $display("FAIL beq: got t=%b z=%b ty=%b exp 1 1 000", branch_taken, zero, branch_type); end
        drive(enc_b(3'b001), 32'd5, 32'd5, 32'd0, 32'd0);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bne: got %b exp 0", branch_taken); end
        drive(enc_b(3'b010), 32'd5, 32'd5, 32'd0, 32'd0);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL b010: got %b exp 0", branch_taken); end
        drive(enc_r(7'd0, 3'b000), 32'd5, 32'd5, 32'd0, 32'd0);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL nonbranch_taken: got %b exp 0", branch_taken); end
    endtask

    task automatic test_decode;
        drive({12'd8, 5'd1, 3'b010, 5'd3, 7'b0000011}, 32'h1000, 32'd0, 32'd8, 32'd0);
        checks++; if ({mem_read, mem_to_reg, reg_write, alu_src, mem_write} !== 5'b11110) begin errors++; $display("FAIL lw_ctrl: got %b exp 11110", {mem_read, mem_to_reg, reg_write, alu_src, mem_write}); end
        checks++; if (alu_result !== 32'h1008) begin errors++; $display("FAIL lw_addr: got %h exp 00001008", alu_result); end
        drive({7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011}, 32'h2000, 32'h55, 32'd4, 32'd0);
        checks++; if ({mem_write, mem_read, mem_to_reg, reg_write} !== 4'b1000) begin errors++; $display("FAIL sw_ctrl: got %b exp 1000", {mem_write, mem_read, mem_to_reg, reg_write}); end
        checks++; if (alu_result !== 32'h2004) begin errors++; $display("FAIL sw_addr: got %h exp 00002004", alu_result); end
        drive(32'h000001EF, 32'h777, 32'd0, 32'd0, 32'h100);
        checks++; if (alu_result !== 32'h104 || jump !== 1'b1 || jump_r !== 1'b0 || reg_write !== 1'b1) begin errors++; $display("FAIL jal: got r=%h j=%b jr=%b rw=%b exp 104 1 0 1", alu_result, jump, jump_r, reg_write); end
        drive(32'h000181E7, 32'h777, 32'd0, 32'd0, 32'h200);
        checks++; if (alu_result !== 32'h204 || jump_r !== 1'b1 || jump !== 1'b0) begin errors++; $display("FAIL jalr: got r=%h jr=%b j=%b exp 204 1 0", alu_result, jump_r, jump); end
        drive(32'h400011B7, 32'h777, 32'd0, 32'h40001000, 32'h300);
        checks++; if (alu_result !== 32'h40001000) begin errors++; $display("FAIL lui: got %h exp 40001000", alu_result); end
        drive(32'h00001197, 32'h777, 32'd0, 32'h1000, 32'h300);
        checks++; if (alu_result !== 32'h1300) begin errors++; $display("FAIL auipc: got %h exp 00001300", alu_result); end
    endtask

    task automatic test_traps;
        drive(32'h00000073, 32'd1, 32'd2, 32'd0, 32'd0);
        checks++; if (trap_enter !== 1'b1 || exception_code !== 32'd11 || reg_write !== 1'b0 || trap_exit !== 1'b0) begin errors++; $display("FAIL ecall: got te=%b c=%0d rw=%b tx=%b exp 1 11 0 0", trap_enter, exception_code, reg_write, trap_exit); end
        drive(32'h00100073, 32'd1, 32'd2, 32'd0, 32'd0);
        checks++; if (trap_enter !== 1'b1 || exception_code !== 32'd3) begin errors++; $display("FAIL ebreak: got te=%b c=%0d exp 1 3", trap_enter, exception_code); end
        drive(32'h30200073, 32'd1, 32'd2, 32'd0, 32'd0);
        checks++; if (trap_exit !== 1'b1 || trap_enter !== 1'b0 || exception_code !== 32'd0) begin errors++; $display("FAIL mret: got tx=%b te=%b c=%0d exp 1 0 0", trap_exit, trap_enter, exception_code); end
        drive(32'h0000007F, 32'd1, 32'd2, 32'd0, 32'd0);
        checks++; if (trap_enter !== 1'b1 || exception_code !== 32'd2 || {reg_write, mem_read, mem_write, branch, jump, jump_r} !== 6'd0) begin errors++; $display("FAIL illegal_op: got te=%b c=%0d ctl=%b exp 1 2 000000", trap_enter, exception_code, {reg_write, mem_read, mem_write, branch, jump, jump_r}); end
        drive(32'h10500073, 32'd1, 32'd2, 32'd0, 32'd0);
        checks++; if (trap_enter !== 1'b1 || exception_code !== 32'd2) begin errors++; $display("FAIL illegal_sys: got te=%b c=%0d exp 1 2", trap_enter, exception_code); end
        drive({12'h300, 5'd0, 3'b010, 5'd5, 7'h73}, 32'd0, 32'd0, 32'd0, 32'd0);
        checks++; if ({is_csr, csr_read_en, csr_write_en, reg_write, trap_enter} !== 5'b11010) begin errors++; $display("FAIL csrrs_x0: got %b exp 11010", {is_csr, csr_read_en, csr_write_en, reg_write, trap_enter}); end
        drive({12'h300, 5'd0, 3'b001, 5'd0, 7'h73}, 32'd0, 32'd0, 32'd0, 32'd0);
        checks++; if ({is_csr, csr_write_en, reg_write} !== 3'b110) begin errors++; $display("FAIL csrrw_rd0: got %b exp 110", {is_csr, csr_write_en, reg_write}); end
        drive({12'h300, 5'd7, 3'b111, 5'd5, 7'h73}, 32'd0, 32'd0, 32'd0, 32'd0);
        checks++; if (csr_write_en !== 1'b1) begin errors++; $display("FAIL csrrci_nz: got %b exp 1", csr_write_en); end
    endtask

    task automatic test_instret_reset;
        @(negedge clk);
        checks++; if (instret === 32'd0) begin errors++; $display("FAIL instret_running: got 0 exp nonzero"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL instret_midreset: got %0d exp 0", instret); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (instret !== 32'd2) begin errors++; $display("FAIL instret_restart: got %0d exp 2", instret); end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_itype;
        test_mdiv;
        test_branch;
        test_decode;
        test_traps;
        test_instret_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
